// File: rtl/instr_encoder.sv
// instr_encoder -- sequential MIPS instruction encoder.
//
// Takes field-level instruction requests (opcode, funct, register numbers,
// immediate) and emits 32-bit machine words from a single output register.
// The subset covered is exactly what the core's control decoder implements.
// Unsupported requests are consumed, produce no word, and raise a one-cycle
// Illegal_o pulse.
//
// Build option: define ENC_PSEUDO_EN to enable the LI pseudo-op (opcode
// 6'b111111). When it is enabled, LI expands to one addi word, or to three
// words: ori / sll / ori. When ENC_PSEUDO_EN is undefined, LI is rejected
// as unsupported.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   Valid_i / Ready_o     request handshake
//   Opcode_i, Funct_i     opcode and R-type funct
//   Rs_i, Rt_i, Rd_i      register numbers
//   Shamt_i               shift amount
//   Imm_i                 immediate / jump target / LI value
//   Instr_o               encoded word
//   InstrValid_o / InstrReady_i  word handshake
//   Illegal_o             registered pulse, one per dropped request
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        Valid_i,
  output logic        Ready_o,
  input  logic [5:0]  Opcode_i,
  input  logic [5:0]  Funct_i,
  input  logic [4:0]  Rs_i,
  input  logic [4:0]  Rt_i,
  input  logic [4:0]  Rd_i,
  input  logic [4:0]  Shamt_i,
  input  logic [31:0] Imm_i,
  output logic [31:0] Instr_o,
  output logic        InstrValid_o,
  input  logic        InstrReady_i,
  output logic        Illegal_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef ENC_PSEUDO_EN
  localparam logic [5:0] OP_LI    = 6'b111111;
`endif

  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;

  logic        dec_legal;
  logic        dec_li_big;
  logic [31:0] dec_word;
  logic        accept;
  logic        idle;
  logic        adv_load;
  logic [31:0] adv_word;

  // Decode the request fields into a legality flag and the first word.
  always_comb begin
    dec_legal  = 1'b0;
    dec_li_big = 1'b0;
    dec_word   = 32'h0000_0000;
    case (Opcode_i)
      OP_RTYPE: begin
        dec_word = {6'b000000, Rs_i, Rt_i, Rd_i, Shamt_i, Funct_i};
        case (Funct_i)
          6'b000000, 6'b000010, 6'b000011,            // sll srl sra
          6'b001000, 6'b001001,                       // jr jalr
          6'b100000, 6'b100010, 6'b100100, 6'b100101, // add sub and or
          6'b100110, 6'b100111, 6'b101010:            // xor nor slt
            dec_legal = 1'b1;
          default:
            dec_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        dec_legal = 1'b1;
        dec_word  = {Opcode_i, Imm_i[25:0]};
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW: begin
        dec_legal = 1'b1;
        dec_word  = {Opcode_i, Rs_i, Rt_i, Imm_i[15:0]};
      end
`ifdef ENC_PSEUDO_EN
      OP_LI: begin
        dec_legal = 1'b1;
        // The value fits in one addi only when bits 31:15 are all copies of bit 15.
        if (Imm_i[31:15] == {17{Imm_i[15]}}) begin
          dec_word = {OP_ADDI, 5'd0, Rt_i, Imm_i[15:0]};
        end else begin
          dec_li_big = 1'b1;
          dec_word   = {OP_ORI, 5'd0, Rt_i, Imm_i[31:16]};
        end
      end
`endif
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign accept  = Valid_i && Ready_o;
  assign Ready_o = idle && (!valid_q || InstrReady_i);

`ifdef ENC_PSEUDO_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LI_SLL = 2'd1,
    LI_LO  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  li_rt_q, li_rt_d;
  logic [15:0] li_lo_q, li_lo_d;

  // LI sequencer state and the fields saved for the later LI words.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      li_rt_q <= 5'd0;
      li_lo_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      li_rt_q <= li_rt_d;
      li_lo_q <= li_lo_d;
    end
  end

  // LI next-state logic and the word loaded on each advance.
  always_comb begin
    state_d  = state_q;
    li_rt_d  = li_rt_q;
    li_lo_d  = li_lo_q;
    adv_load = 1'b0;
    adv_word = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (accept && dec_li_big) begin
          state_d = LI_SLL;
          li_rt_d = Rt_i;
          li_lo_d = Imm_i[15:0];
        end else begin
          state_d = IDLE;
        end
      end
      LI_SLL: begin
        // The output register always holds a valid word here, so a ready
        // output means the current word is being consumed.
        if (InstrReady_i) begin
          state_d  = LI_LO;
          adv_load = 1'b1;
          adv_word = {6'b000000, 5'd0, li_rt_q, li_rt_q, 5'd16, 6'b000000};
        end else begin
          state_d = LI_SLL;
        end
      end
      LI_LO: begin
        if (InstrReady_i) begin
          state_d  = IDLE;
          adv_load = 1'b1;
          adv_word = {OP_ORI, li_rt_q, li_rt_q, li_lo_q};
        end else begin
          state_d = LI_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign idle = (state_q == IDLE);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^Imm_i[31:26];
  assign idle     = 1'b1;
  assign adv_load = 1'b0;
  assign adv_word = 32'h0000_0000;
`endif

  // Output register next value: a new accept wins, then an LI advance, then a drain.
  always_comb begin
    instr_d   = instr_q;
    valid_d   = valid_q;
    illegal_d = accept && !dec_legal;
    if (accept && dec_legal) begin
      instr_d = dec_word;
      valid_d = 1'b1;
    end else if (adv_load) begin
      instr_d = adv_word;
      valid_d = 1'b1;
    end else if (InstrReady_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output word, valid flag and illegal pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      instr_q   <= 32'h0000_0000;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign Instr_o      = instr_q;
  assign InstrValid_o = valid_q;
  assign Illegal_o    = illegal_q;

endmodule
